// File: rtl/dmem_pkg.sv
// Shared encodings for the MEM-stage data-memory responder: op codes,
// FSM states and the word-alignment check.
package dmem_pkg;

  localparam logic [1:0] MEM_OP_NONE    = 2'b00;
  localparam logic [1:0] MEM_OP_STORE   = 2'b01;
  localparam logic [1:0] MEM_OP_LOAD    = 2'b10;
  localparam logic [1:0] MEM_OP_ILLEGAL = 2'b11;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_e;

  function automatic logic req_is_legal(input logic [1:0] op, input logic [31:0] addr);
    return ((op == MEM_OP_STORE) || (op == MEM_OP_LOAD)) &&
           ((addr & WORD_ALIGN_MASK) == 32'h0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM. The read register holds its value
// until the next read; RAM contents are never reset.
module dmem_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1 << DEPTH_LOG2)-1];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: captures one request, stalls the pipeline
// for a fixed latency, performs the word access and pulses done for one cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  dmem_state_e           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [1:0]            op_q, op_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  bad_q, bad_d;

  logic                  legal;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  acc;
  logic [1:0]            acc_op;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic [31:0]           acc_wdata;
  logic                  ram_we, ram_re;

  assign legal   = req_is_legal(req_op, req_addr);
  assign req_idx = req_addr[DEPTH_LOG2+1:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
      op_q    <= MEM_OP_NONE;
      idx_q   <= '0;
      wdata_q <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    bad_d     = bad_q;
    stall     = 1'b0;
    acc       = 1'b0;
    acc_op    = op_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    case (state_q)
      DMEM_IDLE: begin
        if (req_op != MEM_OP_NONE) begin
          stall = 1'b1;
          op_d  = req_op;
          if (!legal) begin
            bad_d   = 1'b1;
            state_d = DMEM_DONE;
          end else begin
            bad_d   = 1'b0;
            idx_d   = req_idx;
            wdata_d = req_wdata;
            cnt_d   = CNT_INIT;
            // Single-cycle latency accesses straight from the request inputs.
            if (LATENCY == 1) begin
              acc       = 1'b1;
              acc_op    = req_op;
              acc_idx   = req_idx;
              acc_wdata = req_wdata;
              state_d   = DMEM_DONE;
            end else begin
              state_d = DMEM_BUSY;
            end
          end
        end
      end
      DMEM_BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          acc     = 1'b1;
          state_d = DMEM_DONE;
        end
      end
      DMEM_DONE: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
  end

  // Gate with reset so nothing is written while reset is held low.
  assign ram_we = acc && reset && (acc_op == MEM_OP_STORE);
  assign ram_re = acc && reset && (acc_op == MEM_OP_LOAD);

  dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .rst_n (reset),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (acc_idx),
    .wdata (acc_wdata),
    .rdata (rdata)
  );

  assign done        = (state_q == DMEM_DONE);
  assign rdata_valid = done && !bad_q && (op_q == MEM_OP_LOAD);
  assign err         = done && bad_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance driven from a
// vector table plus hand sequences, and a LATENCY=1 instance for back-to-back.
module tb_dmem_responder;

  logic        clk;
  logic        reset;

  logic [1:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, rdata_valid, err;
  logic [31:0] rdata;

  logic [1:0]  req_op1;
  logic [31:0] req_addr1, req_wdata1;
  logic        stall1, done1, rdata_valid1, err1;
  logic [31:0] rdata1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .done(done), .rdata(rdata),
    .rdata_valid(rdata_valid), .err(err)
  );

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_op(req_op1), .req_addr(req_addr1),
    .req_wdata(req_wdata1), .stall(stall1), .done(done1), .rdata(rdata1),
    .rdata_valid(rdata_valid1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stalls;
    logic        err;
    logic        rv;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // Issue one request to the LATENCY=2 instance; returns on the DONE cycle.
  task automatic do_req(input string name, input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_stalls, input logic exp_err,
                        input logic exp_rv, input logic [31:0] exp_rdata);
    int  n;
    bit  got;
    @(posedge clk);
    #1;
    req_op = op; req_addr = addr; req_wdata = wdata;
    n = 0;
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1;
      else if (stall) n++;
    end
    chk({name, "_done_seen"}, 32'(got), 32'd1);
    chk({name, "_stalls"}, n, exp_stalls);
    chk({name, "_stall_in_done"}, 32'(stall), 32'd0);
    chk({name, "_err"}, 32'(err), 32'(exp_err));
    chk({name, "_rvalid"}, 32'(rdata_valid), 32'(exp_rv));
    chk({name, "_rdata"}, rdata, exp_rdata);
  endtask

  // Issue one request to the LATENCY=1 instance: one stall cycle, then DONE.
  task automatic req1(input string name, input logic [1:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic exp_err, input logic exp_rv,
                      input logic [31:0] exp_rdata);
    @(posedge clk);
    #1;
    req_op1 = op; req_addr1 = addr; req_wdata1 = wdata;
    @(negedge clk);
    chk({name, "_stall"}, {stall1, done1}, 32'b10);
    @(negedge clk);
    chk({name, "_done"}, {stall1, done1}, 32'b01);
    chk({name, "_err"}, 32'(err1), 32'(exp_err));
    chk({name, "_rvalid"}, 32'(rdata_valid1), 32'(exp_rv));
    chk({name, "_rdata"}, rdata1, exp_rdata);
  endtask

  initial begin
    vecs[0]  = '{2'b01, 32'h0000_0010, 32'hDEAD_BEEF, 2, 1'b0, 1'b0, 32'h0000_0000};
    vecs[1]  = '{2'b10, 32'h0000_0010, 32'h0,         2, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{2'b10, 32'h0000_0013, 32'h0,         1, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[3]  = '{2'b10, 32'h0000_0010, 32'h0,         2, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[4]  = '{2'b01, 32'h0000_0000, 32'h1111_1111, 2, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[5]  = '{2'b11, 32'h0000_0000, 32'h9999_9999, 1, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[6]  = '{2'b10, 32'h0000_0000, 32'h0,         2, 1'b0, 1'b1, 32'h1111_1111};
    vecs[7]  = '{2'b01, 32'h0000_0000, 32'hA5A5_A5A5, 2, 1'b0, 1'b0, 32'h1111_1111};
    vecs[8]  = '{2'b10, 32'h0000_1000, 32'h0,         2, 1'b0, 1'b1, 32'hA5A5_A5A5};
    vecs[9]  = '{2'b01, 32'h0000_0020, 32'hCAFE_F00D, 2, 1'b0, 1'b0, 32'hA5A5_A5A5};
    vecs[10] = '{2'b01, 32'h0000_0022, 32'h7777_7777, 1, 1'b1, 1'b0, 32'hA5A5_A5A5};
    vecs[11] = '{2'b10, 32'h0000_0020, 32'h0,         2, 1'b0, 1'b1, 32'hCAFE_F00D};

    reset = 1'b0;
    req_op = 2'b00; req_addr = '0; req_wdata = '0;
    req_op1 = 2'b00; req_addr1 = '0; req_wdata1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rvalid", 32'(rdata_valid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst1_outs", {stall1, done1, err1, rdata_valid1}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata,
             vecs[i].stalls, vecs[i].err, vecs[i].rv, vecs[i].rdata);
    end

    // Reset during BUSY abandons the pending store.
    @(posedge clk);
    #1;
    req_op = 2'b01; req_addr = 32'h20; req_wdata = 32'h0000_1234;
    @(negedge clk);
    chk("abort_stall_idle", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    chk("abort_stall_busy", 32'(stall), 32'd1);
    reset = 1'b0;
    req_op = 2'b00;
    #1;
    chk("abort_outs", {stall, done, err, rdata_valid}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    do_req("after_abort", 2'b10, 32'h20, 32'h0, 2, 1'b0, 1'b1, 32'hCAFE_F00D);
    @(posedge clk);
    #1;
    req_op = 2'b00;

    // LATENCY=1: preload, then three back-to-back loads and an illegal op.
    req1("l1_st0", 2'b01, 32'h4, 32'h0000_0100, 1'b0, 1'b0, 32'h0);
    req1("l1_st1", 2'b01, 32'h8, 32'h0000_0200, 1'b0, 1'b0, 32'h0);
    req1("l1_st2", 2'b01, 32'hC, 32'h0000_0300, 1'b0, 1'b0, 32'h0);
    req1("l1_ld0", 2'b10, 32'h4, 32'h0, 1'b0, 1'b1, 32'h0000_0100);
    req1("l1_ld1", 2'b10, 32'h8, 32'h0, 1'b0, 1'b1, 32'h0000_0200);
    req1("l1_ld2", 2'b10, 32'hC, 32'h0, 1'b0, 1'b1, 32'h0000_0300);
    req1("l1_bad", 2'b11, 32'h4, 32'h0, 1'b1, 1'b0, 32'h0000_0300);
    req1("l1_ld3", 2'b10, 32'h4, 32'h0, 1'b0, 1'b1, 32'h0000_0100);
    @(posedge clk);
    #1;
    req_op1 = 2'b00;
    @(negedge clk);
    chk("l1_idle", {stall1, done1}, 32'b00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
